// File: rtl/vga_sync_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), the VGA_TOTAL macro and sync helpers.
// Pixel sources import this package so raster geometry has a single source of truth.
`ifndef VGA_TIMING_VH
`define VGA_TIMING_VH
`define VGA_TOTAL(vis, front, sync, back) ((vis) + (front) + (sync) + (back))
`endif

package vga_sync_pkg;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = `VGA_TOTAL(VGA_H_VISIBLE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = `VGA_TOTAL(VGA_V_VISIBLE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

    localparam int VGA_H_SYNC_POL = 0;
    localparam int VGA_V_SYNC_POL = 0;

    // Pin level for a sync pulse given whether it is active and its active polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction
endpackage

// File: rtl/vga_sync_if.sv
// Raster interface between vga_sync (master) and a pixel source (slave).
// Lookahead signals exist only when VGA_SYNC_LOOKAHEAD_EN is defined.
interface vga_sync_if #(
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 10
) ();
    logic                enable_i;
    logic                hsync_o;
    logic                vsync_o;
    logic                visible_o;
    logic [COL_BITS-1:0] column_o;
    logic [ROW_BITS-1:0] row_o;
    logic                line_start_o;
    logic                frame_start_o;
`ifdef VGA_SYNC_LOOKAHEAD_EN
    logic [COL_BITS-1:0] next_column_o;
    logic [ROW_BITS-1:0] next_row_o;
    logic                next_visible_o;
`endif

    modport master (
        input  enable_i,
`ifdef VGA_SYNC_LOOKAHEAD_EN
        output next_column_o, next_row_o, next_visible_o,
`endif
        output hsync_o, vsync_o, visible_o, column_o, row_o, line_start_o, frame_start_o
    );

    modport slave (
        output enable_i,
`ifdef VGA_SYNC_LOOKAHEAD_EN
        input  next_column_o, next_row_o, next_visible_o,
`endif
        input  hsync_o, vsync_o, visible_o, column_o, row_o, line_start_o, frame_start_o
    );
endinterface

// File: rtl/vga_counter.sv
// Wrapping counter 0..TOTAL-1; wrap_o is a combinational flag for the increment that rolls over.
module vga_counter #(
    parameter int WIDTH = 10,
    parameter int TOTAL = 800
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        wrap_o     = inc_i && (count_reg == LAST);
        count_next = count_reg;
        if (inc_i) begin
            count_next = wrap_o ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_o = count_reg;
endmodule

// File: rtl/vga_sync.sv
// VGA raster timing generator: chained h/v counters plus one registered decode stage.
// Optional build macro VGA_SYNC_LOOKAHEAD_EN exposes the unregistered counter decode.
module vga_sync
    import vga_sync_pkg::*;
#(
    parameter int H_VISIBLE  = VGA_H_VISIBLE,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int V_VISIBLE  = VGA_V_VISIBLE,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter int H_SYNC_POL = VGA_H_SYNC_POL,
    parameter int V_SYNC_POL = VGA_V_SYNC_POL,
    parameter int COL_BITS   = 10,
    parameter int ROW_BITS   = 10
) (
    input  logic clk_i,
    input  logic reset_i,
    vga_sync_if.master vif
);
    localparam int H_TOTAL = `VGA_TOTAL(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = `VGA_TOTAL(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [COL_BITS-1:0] H_VIS_END  = COL_BITS'(H_VISIBLE);
    localparam logic [COL_BITS-1:0] H_SYNC_BEG = COL_BITS'(H_VISIBLE + H_FRONT);
    localparam logic [COL_BITS-1:0] H_SYNC_END = COL_BITS'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [ROW_BITS-1:0] V_VIS_END  = ROW_BITS'(V_VISIBLE);
    localparam logic [ROW_BITS-1:0] V_SYNC_BEG = ROW_BITS'(V_VISIBLE + V_FRONT);
    localparam logic [ROW_BITS-1:0] V_SYNC_END = ROW_BITS'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic H_POL = H_SYNC_POL[0];
    localparam logic V_POL = V_SYNC_POL[0];

    logic [COL_BITS-1:0] h_cnt;
    logic [ROW_BITS-1:0] v_cnt;
    logic                h_wrap;
    logic                v_wrap_unused;

    vga_counter #(.WIDTH(COL_BITS), .TOTAL(H_TOTAL)) u_h_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .inc_i  (vif.enable_i),
        .count_o(h_cnt),
        .wrap_o (h_wrap)
    );

    vga_counter #(.WIDTH(ROW_BITS), .TOTAL(V_TOTAL)) u_v_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .inc_i  (h_wrap),
        .count_o(v_cnt),
        .wrap_o (v_wrap_unused)
    );

    logic dec_visible, dec_hsync, dec_vsync, dec_line_start, dec_frame_start;

    always_comb begin
        dec_visible     = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        dec_hsync       = sync_level((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END), H_POL);
        dec_vsync       = sync_level((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END), V_POL);
        dec_line_start  = (h_cnt == '0);
        dec_frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    logic                hsync_reg, vsync_reg, visible_reg, line_start_reg, frame_start_reg;
    logic [COL_BITS-1:0] column_reg;
    logic [ROW_BITS-1:0] row_reg;

    // Strobes hold with everything else while stalled; consumers qualify them with enable.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hsync_reg       <= sync_level(1'b0, H_POL);
            vsync_reg       <= sync_level(1'b0, V_POL);
            visible_reg     <= 1'b0;
            column_reg      <= '0;
            row_reg         <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else if (vif.enable_i) begin
            hsync_reg       <= dec_hsync;
            vsync_reg       <= dec_vsync;
            visible_reg     <= dec_visible;
            column_reg      <= h_cnt;
            row_reg         <= v_cnt;
            line_start_reg  <= dec_line_start;
            frame_start_reg <= dec_frame_start;
        end
    end

    assign vif.hsync_o       = hsync_reg;
    assign vif.vsync_o       = vsync_reg;
    assign vif.visible_o     = visible_reg;
    assign vif.column_o      = column_reg;
    assign vif.row_o         = row_reg;
    assign vif.line_start_o  = line_start_reg;
    assign vif.frame_start_o = frame_start_reg;

`ifdef VGA_SYNC_LOOKAHEAD_EN
    // Counters sit at 0 during reset, so only the visible flag needs masking there.
    assign vif.next_column_o  = h_cnt;
    assign vif.next_row_o     = v_cnt;
    assign vif.next_visible_o = dec_visible && !reset_i;
`endif
endmodule

// File: tb/tb_vga_sync.sv
// Scoreboarded bench for vga_sync using a reduced raster (24x14) so whole frames run quickly.
module tb_vga_sync;
    import vga_sync_pkg::*;

    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8,  VF = 2, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CB = 5, RB = 4;

    typedef logic [13:0] vec_t; // {hs, vs, vis, col[4:0], row[3:0], ls, fs}
    localparam vec_t RST_VEC = {1'b1, 1'b1, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_sync_if #(.COL_BITS(CB), .ROW_BITS(RB)) vif ();

    vga_sync #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .COL_BITS(CB), .ROW_BITS(RB)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .vif    (vif)
    );

    vec_t sb[$];
    vec_t last_exp = RST_VEC;
    int   mc = 0, mr = 0;
    int   n_vec = 0, n_err = 0, n_en = 0;
    int   hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, ls_cnt = 0, max_row = 0;

    function automatic vec_t model(input int c, input int r);
        logic hs, vs, vis, ls, fs;
        logic [4:0] cv;
        logic [3:0] rv;
        hs  = !(c >= HV + HF && c < HV + HF + HS);
        vs  = !(r >= VV + VF && r < VV + VF + VS);
        vis = (c < HV) && (r < VV);
        ls  = (c == 0);
        fs  = (c == 0) && (r == 0);
        cv  = 5'(c);
        rv  = 4'(r);
        return {hs, vs, vis, cv, rv, ls, fs};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, want);
            $error("%s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic step(input logic en, input logic rs);
        vec_t exp, obs;
        vif.enable_i = en;
        rst          = rs;
`ifdef VGA_SYNC_LOOKAHEAD_EN
        #1;
        if (en && !rs) begin
            check("next_column", 32'(vif.next_column_o), 32'(mc));
            check("next_row", 32'(vif.next_row_o), 32'(mr));
            check("next_visible", 32'(vif.next_visible_o), 32'((mc < HV) && (mr < VV)));
        end
`endif
        if (rs) begin
            exp = RST_VEC;
            mc  = 0;
            mr  = 0;
        end else if (en) begin
            exp = model(mc, mr);
            if (mc == HT - 1) begin
                mc = 0;
                mr = (mr == VT - 1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end else begin
            exp = last_exp;
        end
        last_exp = exp;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        obs = {vif.hsync_o, vif.vsync_o, vif.visible_o, vif.column_o, vif.row_o,
               vif.line_start_o, vif.frame_start_o};
        check(rs ? "reset_px" : (en ? "run_px" : "hold_px"), 32'(obs), 32'(sb.pop_front()));
        if (en && !rs) begin
            n_en++;
            if (!obs[13]) hs_cnt++;
            if (!obs[12]) vs_cnt++;
            if (obs[1]) ls_cnt++;
            if (obs[0]) fs_cnt++;
            if (int'(obs[5:2]) > max_row) max_row = int'(obs[5:2]);
        end
    endtask

    initial begin
        vif.enable_i = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        // First enabled cycle loads pixel (0,0).
        step(1'b1, 1'b0);
        while (mc != 10) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        while (n_en < 2 * FRAME) step(1'b1, 1'b0);

        check("hsync_cycles", 32'(hs_cnt), 32'(2 * VT * HS));
        check("vsync_cycles", 32'(vs_cnt), 32'(2 * VS * HT));
        check("line_starts", 32'(ls_cnt), 32'(2 * VT));
        check("frame_starts", 32'(fs_cnt), 32'(2));
        check("max_row", 32'(max_row), 32'(VT - 1));

        // Mid-frame reset with enable high: reset must win.
        while (!(mc == 7 && mr == 5)) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("frame_start_after_reset", 32'(vif.frame_start_o), 32'(1));
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
